// File: rtl/ldl_fifo_rd_stream_v1.sv
// rtl/ldl_fifo_rd_stream_v1.sv - async FIFO read port to valid/ready stream adapter with credit-based skid buffer
// Optional beat counter (o_beats/o_beats_clr) enabled by defining LDL_FIFO_RD_STREAM_CNT_EN.
module ldl_fifo_rd_stream_v1 #(
  parameter  int DW     = 8,
  parameter  int RD_LAT = 1,
  localparam int DEPTH  = RD_LAT + 1,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          f_empty,
  output logic          f_re,
  input  logic [DW-1:0] f_dout,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_level
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]   o_beats,
  input  logic          o_beats_clr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = LW + 1;

  logic [DW-1:0]     mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nx;
  logic [RD_LAT-1:0] inflight;
  logic [CW-1:0]     flight;
  logic [LW-1:0]     level_nx;
  logic              pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    flight = '0;
    for (int i = 0; i < RD_LAT; i++) flight = flight + CW'(inflight[i]);
  end

  assign pop  = o_valid & o_ready;
  assign push = inflight[RD_LAT-1];

  // Credit: every issued read already owns a buffer slot, so a landing word is never dropped.
  assign f_re = rst & en & ~f_empty & ((CW'(o_level) + flight) < (CW'(DEPTH) + CW'(pop)));

  assign rd_ptr_nx = pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign level_nx  = o_level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= f_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      o_level  <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else begin
      inflight <= (inflight << 1) | RD_LAT'(f_re);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr  <= rd_ptr_nx;
      o_level <= level_nx;
      o_valid <= (level_nx != '0);
      // A word landing into a slot that becomes the head bypasses the memory read.
      if (level_nx != '0)
        o_data <= (push && (wr_ptr == rd_ptr_nx)) ? f_dout : mem[rd_ptr_nx];
    end
  end

`ifdef LDL_FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             o_beats <= '0;
    else if (o_beats_clr) o_beats <= '0;
    else if (pop)         o_beats <= o_beats + 32'd1;
  end
`endif

  level_bound: assert property (@(posedge clk) disable iff (!rst) o_level <= LW'(DEPTH));

endmodule

// File: tb/tb_ldl_fifo_rd_stream_v1.sv
// tb/tb_ldl_fifo_rd_stream_v1.sv - two-lane bench (RD_LAT=1 and RD_LAT=3) against a count/queue stream model
// Counter checks included when LDL_FIFO_RD_STREAM_CNT_EN is defined.
`timescale 1ns/1ps
module tb_ldl_fifo_rd_stream_v1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en, f_empty, f_re, o_valid, o_ready, hold;
  logic [7:0] f_dout [2];
  logic [7:0] o_data [2];
  logic [2:0] o_level [2];
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
  logic [31:0] o_beats [2];
  logic [1:0]  o_beats_clr;
  int          beats_m [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [$clog2(LAT + 2)-1:0] lvl_w;
    ldl_fifo_rd_stream_v1 #(.DW(8), .RD_LAT(LAT)) u_dut (
      .clk     (clk),
      .rst     (rst_n),
      .en      (en[g]),
      .f_empty (f_empty[g]),
      .f_re    (f_re[g]),
      .f_dout  (f_dout[g]),
      .o_valid (o_valid[g]),
      .o_ready (o_ready[g]),
      .o_data  (o_data[g]),
      .o_level (lvl_w)
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      ,
      .o_beats     (o_beats[g]),
      .o_beats_clr (o_beats_clr[g])
`endif
    );
    assign o_level[g] = 3'(lvl_w);
  end

  int         checks, errors, cyc;
  int         avail [2], rd_ctr [2], exp_ctr [2], lvl_m [2];
  int         infl_q [2][$];
  logic [7:0] pipe [2][4];
  bit         dut_fre [2], mdl_fre [2], mdl_pop [2];
  int         n_fre [2], run [2], maxrun [2], n_pop [2];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, g, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int g = 0; g < 2; g++) f_empty[g] = hold[g] || (avail[g] == 0);
  endtask

  // Model: buffered word count, issue-cycle queue of outstanding reads, next expected word.
  task automatic check_all();
    for (int g = 0; g < 2; g++) begin
      int fl;
      bit p, fr;
      fl = infl_q[g].size();
      p  = (lvl_m[g] > 0) && o_ready[g];
      fr = rst_n && en[g] && !f_empty[g] && ((lvl_m[g] + fl - int'(p)) < lat(g) + 1);
      chk("f_re", g, 32'(f_re[g]), 32'(fr));
      chk("o_valid", g, 32'(o_valid[g]), 32'(lvl_m[g] > 0));
      chk("o_level", g, 32'(o_level[g]), 32'(lvl_m[g]));
      if (lvl_m[g] > 0) chk("o_data", g, 32'(o_data[g]), 32'(exp_ctr[g] & 255));
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      chk("o_beats", g, o_beats[g], 32'(beats_m[g]));
`endif
      dut_fre[g] = f_re[g];
      mdl_fre[g] = fr;
      mdl_pop[g] = p;
      if (f_re[g]) begin
        n_fre[g]++;
        run[g]++;
        if (run[g] > maxrun[g]) maxrun[g] = run[g];
      end else run[g] = 0;
      if (p) n_pop[g]++;
    end
  endtask

  task automatic advance();
    for (int g = 0; g < 2; g++) begin
      for (int i = 3; i > 0; i--) pipe[g][i] = pipe[g][i-1];
      if (dut_fre[g] && avail[g] > 0) begin
        pipe[g][0] = 8'(rd_ctr[g]);
        rd_ctr[g]++;
        avail[g]--;
      end else pipe[g][0] = 8'($urandom);
      f_dout[g] = pipe[g][lat(g)-1];
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      if (o_beats_clr[g]) beats_m[g] = 0;
      else if (mdl_pop[g]) beats_m[g]++;
`endif
      if (mdl_pop[g]) begin
        lvl_m[g]--;
        exp_ctr[g]++;
      end
      if (infl_q[g].size() > 0 && infl_q[g][0] == cyc - lat(g)) begin
        void'(infl_q[g].pop_front());
        lvl_m[g]++;
      end
      if (mdl_fre[g]) infl_q[g].push_back(cyc);
    end
    cyc++;
  endtask

  task automatic step();
    refresh();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    advance();
    refresh();
  endtask

  task automatic clr_stats();
    for (int g = 0; g < 2; g++) begin
      n_fre[g] = 0; run[g] = 0; maxrun[g] = 0; n_pop[g] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_f_re", g, 32'(f_re[g]), 32'd0);
      chk("rst_valid", g, 32'(o_valid[g]), 32'd0);
      chk("rst_level", g, 32'(o_level[g]), 32'd0);
      chk("rst_data", g, 32'(o_data[g]), 32'd0);
      lvl_m[g] = 0;
      infl_q[g].delete();
      exp_ctr[g] = rd_ctr[g];
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      beats_m[g] = 0;
`endif
      for (int i = 0; i < 4; i++) pipe[g][i] = 8'($urandom);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; en = '0; o_ready = '0; hold = '0;
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    o_beats_clr = '0;
`endif
    for (int g = 0; g < 2; g++) begin
      avail[g] = 0; rd_ctr[g] = 0; exp_ctr[g] = 0; lvl_m[g] = 0;
      f_dout[g] = '0;
      for (int i = 0; i < 4; i++) pipe[g][i] = '0;
    end
    clr_stats();
    refresh();
    @(posedge clk);
    #1;
    do_reset();

    // Latency: one word 0xA5 appears at cycle 0, o_valid/o_data at cycle 2.
    en = 2'b11; o_ready = 2'b11;
    rd_ctr[0] = 8'hA5; exp_ctr[0] = 8'hA5; avail[0] = 1;
    refresh();
    #1;
    chk("lat_f_re_c0", 0, 32'(f_re[0]), 32'd1);
    step();
    chk("lat_valid_c1", 0, 32'(o_valid[0]), 32'd0);
    step();
    chk("lat_valid_c2", 0, 32'(o_valid[0]), 32'd1);
    chk("lat_data_c2", 0, 32'(o_data[0]), 32'hA5);
    repeat (4) step();

    // Throughput: 16 words 0x00..0x0F per lane, sink always ready.
    for (int g = 0; g < 2; g++) begin
      rd_ctr[g] = 0; exp_ctr[g] = 0;
    end
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    o_beats_clr = 2'b11;
    step();
    o_beats_clr = 2'b00;
`endif
    clr_stats();
    avail[0] = 16; avail[1] = 16;
    repeat (30) step();
    for (int g = 0; g < 2; g++) begin
      chk("thr_fre_total", g, 32'(n_fre[g]), 32'd16);
      chk("thr_fre_run", g, 32'(maxrun[g]), 32'd16);
      chk("thr_pops", g, 32'(n_pop[g]), 32'd16);
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      chk("thr_beats", g, o_beats[g], 32'd16);
`endif
    end

    // Backpressure: 10-cycle stall mid-stream, then gapless resume.
    avail[0] += 40; avail[1] += 40;
    repeat (6) step();
    o_ready = 2'b00;
    repeat (10) step();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("bp_level_full", g, 32'(o_level[g]), 32'(lat(g) + 1));
      chk("bp_f_re_off", g, 32'(f_re[g]), 32'd0);
    end
    o_ready = 2'b11;
    clr_stats();
    repeat (10) step();
    for (int g = 0; g < 2; g++) chk("bp_resume_pops", g, 32'(n_pop[g]), 32'd10);

    // Reset mid-burst with words buffered.
    o_ready = 2'b00;
    avail[0] += 10; avail[1] += 10;
    repeat (8) step();
    chk("pre_rst_level", 0, 32'(o_level[0]), 32'd2);
    do_reset();
    o_ready = 2'b11;
    repeat (10) step();

    // Random traffic: en toggles, empty pulses, backpressure, pointer wrap.
    for (int n = 0; n < 3000; n++) begin
      for (int g = 0; g < 2; g++) begin
        en[g]      = ($urandom % 10) != 0;
        o_ready[g] = ($urandom % 4) != 0;
        hold[g]    = ($urandom % 16) == 0;
        if (($urandom % 3) == 0) avail[g] += int'($urandom % 4);
      end
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
      o_beats_clr = ($urandom % 64) == 0 ? 2'b11 : 2'b00;
`endif
      step();
    end

    // en low: outstanding reads still land and drain; nothing is lost.
`ifdef LDL_FIFO_RD_STREAM_CNT_EN
    o_beats_clr = 2'b00;
`endif
    en = 2'b00; hold = 2'b00; o_ready = 2'b11;
    repeat (12) step();
    for (int g = 0; g < 2; g++) begin
      chk("drain_valid", g, 32'(o_valid[g]), 32'd0);
      chk("drain_all_delivered", g, 32'(exp_ctr[g]), 32'(rd_ctr[g]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
